// File: rtl/pcs_tx_gearbox.sv
// 66b->64b transmit gearbox: 32 blocks per lane in, 33 PMA words out, all lanes in lockstep.
// Optional sync-header check is built only when PCS_GB_CHECK_EN is defined.
`timescale 1ns/1ps

module pcs_tx_gearbox #(
    parameter int LANE_N = 4,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64,
    parameter int PMA_W  = 64
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [LANE_N*HEAD_W-1:0]   head_i,
    input  logic [LANE_N*DATA_W-1:0]   data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [LANE_N*PMA_W-1:0]    lane_o,
    output logic [LANE_N-1:0]          err_o
);

    localparam int         BLK_W    = HEAD_W + DATA_W;
    localparam int         CMB_W    = 2 * PMA_W;
    localparam logic [5:0] SEQ_LAST = 6'd32;

    typedef enum logic [0:0] {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } gb_state_t;

    gb_state_t  r_state;
    logic [5:0] r_seq;
    logic       r_ready;
    logic       r_valid;
    logic [5:0] w_seq_nxt;
    logic       w_accept;
    logic       w_flush;

`ifdef PCS_GB_CHECK_EN
    // Only 01 and 10 are legal sync headers.
    function automatic logic hdr_bad(input logic [HEAD_W-1:0] hdr);
        return hdr[0] ~^ hdr[1];
    endfunction
`endif

    // Sequence step and per-cycle action decode.
    always_comb begin
        w_seq_nxt = 6'd0;
        if (r_seq == SEQ_LAST) begin
            w_seq_nxt = 6'd0;
        end else begin
            w_seq_nxt = r_seq + 6'd1;
        end
        w_accept = (r_state == ST_RUN) && (r_seq != SEQ_LAST);
        w_flush  = (r_state == ST_RUN) && (r_seq == SEQ_LAST);
    end

    // Control FSM: one idle edge after reset, then seq runs 0..32 continuously.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= ST_RESET;
            r_seq   <= 6'd0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_RUN;
                    r_seq   <= 6'd0;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_seq   <= w_seq_nxt;
                    r_ready <= (w_seq_nxt != SEQ_LAST);
                    r_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_RESET;
                    r_seq   <= 6'd0;
                    r_ready <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;

    for (genvar gi = 0; gi < LANE_N; gi++) begin : g_lane
        logic [BLK_W-1:0] w_blk;
        logic [CMB_W-1:0] w_cmb;
        logic [PMA_W-1:0] r_res;
        logic [PMA_W-1:0] r_word;

        // New block lands above the 2*seq residual bits; residual bits above that are always zero.
        always_comb begin
            w_blk = {data_i[gi*DATA_W +: DATA_W], head_i[gi*HEAD_W +: HEAD_W]};
            w_cmb = ({{(CMB_W-BLK_W){1'b0}}, w_blk} << {r_seq[4:0], 1'b0})
                  | {{(CMB_W-PMA_W){1'b0}}, r_res};
        end

        // Output word and residual registers.
        always_ff @(posedge clk) begin
            if (!nreset) begin
                r_word <= {PMA_W{1'b0}};
                r_res  <= {PMA_W{1'b0}};
            end else if (w_accept) begin
                r_word <= w_cmb[PMA_W-1:0];
                r_res  <= w_cmb[CMB_W-1:PMA_W];
            end else if (w_flush) begin
                r_word <= r_res;
                r_res  <= {PMA_W{1'b0}};
            end else begin
                r_word <= r_word;
                r_res  <= r_res;
            end
        end

        assign lane_o[gi*PMA_W +: PMA_W] = r_word;

`ifdef PCS_GB_CHECK_EN
        logic r_err;

        // Sticky bad-header flag, evaluated only on accepted blocks.
        always_ff @(posedge clk) begin
            if (!nreset) begin
                r_err <= 1'b0;
            end else if (w_accept && hdr_bad(head_i[gi*HEAD_W +: HEAD_W])) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end

        assign err_o[gi] = r_err;
`endif
    end

`ifndef PCS_GB_CHECK_EN
    assign err_o = {LANE_N{1'b0}};
`endif

endmodule

// File: doc/pcs_tx_gearbox.md
PCS_TX_GEARBOX -- requirements
Module: pcs_tx_gearbox

Interface
REQ-001 SHALL have parameters: LANE_N, 4, number of PCS lanes; HEAD_W, 2, sync header width; DATA_W, 64, block payload width; PMA_W, 64, output word width per lane (only 64 supported).
REQ-002 SHALL have ports: clk  in  1  clock; nreset  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: head_i  in  LANE_N*HEAD_W  per-lane sync header, from alignment marker insertion; data_i  in  LANE_N*DATA_W  per-lane block payload.
REQ-004 SHALL have ports: ready_o  out  1  block accepted this cycle (shared by all lanes); valid_o  out  1  lane_o holds valid PMA data.
REQ-005 SHALL have ports: lane_o  out  LANE_N*PMA_W  per-lane 64-bit PMA word, bit 0 transmitted first; err_o  out  LANE_N  sticky bad-header flag (only with PCS_GB_CHECK_EN).

Function
REQ-006 SHALL convert each lane's 66-bit block stream to a 64-bit word stream, 33 output words per 32 input blocks.
REQ-007 SHALL serialise each block head first: head[0], head[1], then data[0]..data[63].
REQ-008 SHALL keep one shared sequence counter seq, range 0..32, wrapping 32->0, advancing every cycle out of reset.
REQ-009 SHALL, at seq=s<32, accept the block and form combined={block, residual[2s-1:0]}; output word=combined[63:0]; new residual=combined[2s+65:64] (2s+2 bits).
REQ-010 SHALL, at seq=32, accept no block, output residual[63:0], clear residual.
REQ-011 SHALL register ready_o: high when next seq != 32, so it is low exactly one cycle in every 33.
REQ-012 SHALL ignore head_i/data_i whenever ready_o is low; upstream holds or stalls its block (and its marker gap counter) on those cycles.
REQ-013 SHALL register lane_o; latency from block accept to the word containing its first bit is 1 cycle.
REQ-014 SHALL keep valid_o low until the cycle after the first accepted block, then high continuously.
REQ-015 SHALL treat all lanes in lockstep; data on one lane never affects another lane's output.

Reset
REQ-016 SHALL, while nreset is low at a clk edge: seq=0, residual=0, lane_o=0, valid_o=0, ready_o=0, err_o=0.
REQ-017 SHALL drive ready_o high on the first edge with nreset high; seq starts at 0 on that edge.
REQ-018 SHALL, on reset mid-period, discard residual bits and restart at seq=0 with no partial word output.

Configuration
REQ-019 SHALL gate the header check with the macro PCS_GB_CHECK_EN.
REQ-020 SHALL, with PCS_GB_CHECK_EN defined, set err_o[i] one cycle after an accepted block on lane i has header 2'b00 or 2'b11, sticky until reset; headers on non-accepted cycles are not checked.
REQ-021 SHALL, with PCS_GB_CHECK_EN undefined, tie err_o to 0 and implement no check logic.

Verification
REQ-022 SHALL cover: reset, then 100 cycles with head=2'b01, data=0 -> ready_o low on cycles 33, 66, 99 after the first accept; valid_o high from cycle 2.
REQ-023 SHALL cover: first block head=2'b10, data=64'h0123456789ABCDEF -> first lane_o word={data[61:0],2'b10}; next word bits[1:0]=data[63:62]=2'b00.
REQ-024 SHALL cover: 32 blocks per lane with data=block index, head=2'b01 -> reassembled output bitstream matches serialised input bit-exactly, 33 words, residual 0 at wrap.
REQ-025 SHALL cover: nreset low for one cycle at seq=17 -> next edge lane_o=0, valid_o=0, ready_o=0; ready_o high next edge, seq restarts at 0.
REQ-026 SHALL cover, with PCS_GB_CHECK_EN: lane 2 head=2'b11 on an accepted cycle -> err_o=4'b0100 next cycle and stays set; same header on a ready_o-low cycle -> err_o unchanged.
REQ-027 SHALL cover: distinct data per lane (lane i data=64'hi...i) -> each lane_o slice depends only on its own input.
